song_sequencer: RTL and testbench
=================================

# song_sequencer

Fetches encoded note and wait entries from an external song ROM and drives the chord synthesizer's note interface: `note`, `duration` and a one-cycle `new_note` strobe. Notes that share a time step are issued back-to-back, so the synthesizer builds them into a chord. Time between steps is counted in `beat` pulses from the beat generator. The block sits directly upstream of `chords`, and the two share `clk`, `reset`, `play` and `beat`.

## Interface
- `SONG_BITS`, default 2: song select width; the ROM holds 2^SONG_BITS song regions.
- `ADDR_BITS`, default 7: entries per song region, as log2 (default 128 entries).
- `clk` input 1: system clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `play` input 1: level; high = run, low = pause.
- `song` input SONG_BITS: selected song.
- `beat` input 1: one-cycle beat pulse.
- `rom_addr` output SONG_BITS+ADDR_BITS: registered ROM address = {song_q, ptr}.
- `rom_data` input 16: ROM word, valid one cycle after `rom_addr`.
- `note` output 6: note code; holds its value between issues.
- `duration` output 6: note length in beats; holds its value between issues.
- `new_note` output 1: one-cycle strobe; `note`/`duration` are valid with it.
- `song_done` output 1: one-cycle pulse when the end marker is decoded.

## Operation
- Entry format:
  - bit 15 = 0: note entry. Bits [11:6] = note, bits [5:0] = duration, bits [14:12] are ignored.
  - bit 15 = 1: wait entry. Bits [5:0] = beat count N.
  - A wait entry with N = 0 is the end-of-song marker.
- States: IDLE, FETCH, DECODE, NOTE_OUT, WAIT, DONE.
- IDLE: `ptr` = 0. Goes to FETCH when `play` = 1.
- FETCH: `rom_addr` presents the entry. Goes to DECODE if `play` = 1; otherwise holds in FETCH (pause).
- DECODE: `rom_data` is sampled, then one of:
  - Note entry: latch note and duration, go to NOTE_OUT.
  - Wait entry with N > 0: load the beat counter with N, increment `ptr`, go to WAIT.
  - End marker: pulse `song_done` next cycle, go to DONE.
- NOTE_OUT: assert `new_note` with the updated `note`/`duration`, increment `ptr`, go to FETCH.
- WAIT: each `beat` seen while `play` = 1 decrements the counter. The decrement that takes it to 0 sends the state to FETCH. Beats while `play` = 0 are ignored, and the count is retained.
- DONE: holds. Goes to IDLE when `play` = 0.
- `ptr` increments modulo 2^ADDR_BITS, so it wraps 0x7F→0x00 within the song region and never crosses into the next song.
- Song change:
  - `song_q` registers `song`.
  - If `song` ≠ `song_q` in any state, next cycle `song_q` = `song`, `ptr` = 0, state = IDLE, and the beat counter is cleared.
  - A pending NOTE_OUT strobe is dropped.
  - The song change has priority over every other transition.
- Note entries with duration 0 are issued unchanged; filtering them is the synthesizer's job.
- Reset values: state IDLE, `ptr` 0, `song_q` 0, `rom_addr` 0, `note` 0, `duration` 0, `new_note` 0, `song_done` 0, beat counter 0.

## Timing
- FETCH at cycle t puts the entry address on `rom_addr` (ROM read latency is 1 cycle). DECODE is at t+1 and NOTE_OUT at t+2, with `new_note` high in cycle t+2 only. The next FETCH is at t+3.
- Chord notes are issued 3 cycles apart. This guarantees that `chords` sees at least 2 idle cycles between strobes.
- After the final beat of a wait, FETCH starts the next cycle. The first following `new_note` comes 3 cycles after that beat.
- A `beat` in the same cycle as DECODE of a wait entry is not counted.
- `song_done` is high in the cycle after DECODE of the end marker.
- Reset assertion clears all outputs immediately (asynchronously). Operation resumes in IDLE on the first edge after release.

## Configuration
- `SEQ_LOOP_EN`:
  - Defined: on the end marker, `song_done` still pulses, `ptr` = 0, and the state goes to FETCH, so the song repeats while `play` = 1. DONE is unreachable.
  - Undefined: the end marker enters DONE as described above.

## Test plan
- Basic issue. Song 0 = {note 37 dur 4, wait 1, end}; release reset, `play` = 1:
  - `rom_addr` 0x000 → `new_note` with note = 37, duration = 4, 2 cycles after the first FETCH.
  - `rom_addr` then advances to 0x001.
  - `song_done` pulses 3 cycles after the first subsequent `beat`.
- Chord. Entries {37, 41, 44, wait 4}:
  - Three `new_note` pulses exactly 3 cycles apart, with notes 37, 41, 44.
  - No FETCH until the 4th `beat`; the next `new_note` comes 3 cycles after that beat.
- Pause. Drop `play` after 1 of 3 wait beats, send 5 beats, raise `play`: exactly 2 more beats are needed before the next fetch.
- Song change. Switch `song` 0→1 mid-WAIT:
  - Next cycle: state IDLE, `rom_addr` = 0x080, no strobe.
  - Playback restarts from song 1, entry 0.
- Wrap. Song region filled with 128 note entries and no end marker: `rom_addr` wraps 0x07F→0x000 and `new_note` continues.
- Reset. Assert `reset` low in the NOTE_OUT cycle: `new_note`, `note`, `duration` and `rom_addr` go to 0 without waiting for a clock edge. With `SEQ_LOOP_EN`, the song restarts from entry 0 after `song_done` with no `play` toggle.

Source files
------------

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - song ROM note/wait sequencer feeding the chord synthesizer
// Optional feature: SEQ_LOOP_EN (end marker restarts the song instead of entering DONE)
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous active-low reset
//   play      - level, high = run, low = pause
//   song      - selected song region
//   beat      - one-cycle beat pulse
//   rom_addr  - registered ROM address {song_q, ptr}
//   rom_data  - ROM word, valid one cycle after rom_addr
//   note      - note code, held between issues
//   duration  - note length in beats, held between issues
//   new_note  - one-cycle strobe qualifying note/duration
//   song_done - one-cycle pulse after the end marker is decoded
module song_sequencer #(
  parameter int SONG_BITS = 2,
  parameter int ADDR_BITS = 7
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           play,
  input  logic [SONG_BITS-1:0]           song,
  input  logic                           beat,
  output logic [SONG_BITS+ADDR_BITS-1:0] rom_addr,
  input  logic [15:0]                    rom_data,
  output logic [5:0]                     note,
  output logic [5:0]                     duration,
  output logic                           new_note,
  output logic                           song_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_NOTE_OUT,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [ADDR_BITS-1:0] PTR_ONE = ADDR_BITS'(1);

  state_t               state, state_d;
  logic [ADDR_BITS-1:0] ptr, ptr_d;
  logic [SONG_BITS-1:0] song_q, song_q_d;
  logic [5:0]           beat_cnt, beat_cnt_d;
  logic [5:0]           note_d, duration_d;
  logic                 new_note_d, song_done_d;

  // Bits [14:12] of a note entry carry no meaning for this block.
  logic unused_rom_bits;
  assign unused_rom_bits = ^rom_data[14:12];

  // ptr wraps inside its region; the song bits never change from a pointer carry.
  assign rom_addr = {song_q, ptr};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      song_q    <= '0;
      beat_cnt  <= '0;
      note      <= '0;
      duration  <= '0;
      new_note  <= 1'b0;
      song_done <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      song_q    <= song_q_d;
      beat_cnt  <= beat_cnt_d;
      note      <= note_d;
      duration  <= duration_d;
      new_note  <= new_note_d;
      song_done <= song_done_d;
    end
  end

  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    song_q_d    = song_q;
    beat_cnt_d  = beat_cnt;
    note_d      = note;
    duration_d  = duration;
    new_note_d  = 1'b0;
    song_done_d = 1'b0;

    if (song != song_q) begin
      // A song change overrides everything, including a strobe about to issue.
      song_q_d   = song;
      ptr_d      = '0;
      beat_cnt_d = '0;
      state_d    = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          ptr_d = '0;
          if (play) state_d = S_FETCH;
        end
        S_FETCH: begin
          if (play) state_d = S_DECODE;
        end
        S_DECODE: begin
          if (!rom_data[15]) begin
            // The strobe register is loaded here so it is high exactly in NOTE_OUT.
            note_d     = rom_data[11:6];
            duration_d = rom_data[5:0];
            new_note_d = 1'b1;
            state_d    = S_NOTE_OUT;
          end else if (rom_data[5:0] != 6'd0) begin
            beat_cnt_d = rom_data[5:0];
            ptr_d      = ptr + PTR_ONE;
            state_d    = S_WAIT;
          end else begin
            song_done_d = 1'b1;
`ifdef SEQ_LOOP_EN
            ptr_d   = '0;
            state_d = S_FETCH;
`else
            state_d = S_DONE;
`endif
          end
        end
        S_NOTE_OUT: begin
          ptr_d   = ptr + PTR_ONE;
          state_d = S_FETCH;
        end
        S_WAIT: begin
          if (beat && play) begin
            beat_cnt_d = beat_cnt - 6'd1;
            if (beat_cnt <= 6'd1) state_d = S_FETCH;
          end
        end
        S_DONE: begin
          if (!play) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - self-checking bench for song_sequencer against a timeline model
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        play;
  logic [1:0]  song;
  logic        beat;
  logic [8:0]  rom_addr;
  logic [15:0] rom_data;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        new_note;
  logic        song_done;

  logic [15:0] rom [0:511];

  bit         play_a  [0:1023];
  bit         beat_a  [0:1023];
  bit         exp_nn  [0:1023];
  bit         exp_sd  [0:1023];
  bit         exp_av  [0:1023];
  logic [5:0] exp_note[0:1023];
  logic [5:0] exp_dur [0:1023];
  logic [8:0] exp_addr[0:1023];

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [15:0] END_E = 16'h8000;

  song_sequencer #(.SONG_BITS(2), .ADDR_BITS(7)) dut (
    .clk      (clk),
    .reset    (reset),
    .play     (play),
    .song     (song),
    .beat     (beat),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .note     (note),
    .duration (duration),
    .new_note (new_note),
    .song_done(song_done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM, one cycle read latency.
  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [15:0] note_e(input int n, input int d);
    note_e = {1'b0, 3'($urandom_range(0, 7)), 6'(n), 6'(d)};
  endfunction

  function automatic logic [15:0] wait_e(input int n);
    wait_e = {1'b1, 9'd0, 6'(n)};
  endfunction

  task automatic chk(input string tag, input int cyc, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_region(input int s, input logic [15:0] v);
    for (int i = 0; i < 128; i++) rom[s*128 + i] = v;
  endtask

  // Holds reset across one edge, checks the reset values, releases mid-cycle: cycle 0 follows.
  task automatic do_reset(input logic [1:0] s);
    reset = 1'b0;
    play  = 1'b0;
    beat  = 1'b0;
    song  = s;
    next_cycle();
    chk("rst_rom_addr",  -1, 16'(rom_addr),  16'h0);
    chk("rst_note",      -1, 16'(note),      16'h0);
    chk("rst_duration",  -1, 16'(duration),  16'h0);
    chk("rst_new_note",  -1, 16'(new_note),  16'h0);
    chk("rst_song_done", -1, 16'(song_done), 16'h0);
    reset = 1'b1;
  endtask

  task automatic mark_addr(input int t, input int s, input int ptr);
    exp_av[t]   = 1'b1;
    exp_addr[t] = 9'(s*128 + ptr);
  endtask

  // Walks the song entry by entry and lays out on a cycle timeline where
  // fetches, strobes and done pulses must appear, from the timing rules:
  // fetch t -> strobe t+2, next fetch t+3; a wait counts play-qualified beats
  // from t+2 on and refetches the cycle after the last one; end -> done at t+2.
  task automatic build_expect(input int s, input int n);
    int c, i, t, b, k, j, ptr;
    logic [15:0] e;
    bit done_flag;
    for (int x = 0; x < 1024; x++) begin
      exp_nn[x] = 1'b0;
      exp_sd[x] = 1'b0;
      exp_av[x] = 1'b0;
    end
    // A nonzero song differs from the reset song register, costing one cycle.
    c = (s != 0) ? 1 : 0;
    done_flag = 1'b0;
    while (c < n) begin
      i = c;
      while (i < n && !play_a[i]) i++;
      t = i + 1;
      ptr = 0;
      done_flag = 1'b0;
      while (t < n && !done_flag) begin
        while (t < n && !play_a[t]) begin
          mark_addr(t, s, ptr);
          t++;
        end
        if (t >= n) break;
        mark_addr(t, s, ptr);
        e = rom[s*128 + ptr];
        if (!e[15]) begin
          if (t + 2 < n) begin
            exp_nn[t+2]   = 1'b1;
            exp_note[t+2] = e[11:6];
            exp_dur[t+2]  = e[5:0];
          end
          ptr = (ptr + 1) % 128;
          t = t + 3;
        end else if (e[5:0] != 6'd0) begin
          ptr = (ptr + 1) % 128;
          k = int'(e[5:0]);
          b = t + 2;
          while (b < n) begin
            if (beat_a[b] && play_a[b]) begin
              k--;
              if (k == 0) break;
            end
            b++;
          end
          t = b + 1;
        end else begin
          if (t + 2 < n) exp_sd[t+2] = 1'b1;
`ifdef SEQ_LOOP_EN
          ptr = 0;
          t = t + 2;
`else
          done_flag = 1'b1;
`endif
        end
      end
      if (!done_flag) break;
      j = t + 2;
      while (j < n && play_a[j]) j++;
      c = j + 1;
    end
  endtask

  task automatic run_model(input int s, input int n);
    build_expect(s, n);
    do_reset(2'(s));
    for (int c = 0; c < n; c++) begin
      play = play_a[c];
      beat = beat_a[c];
      chk("new_note",  c, 16'(new_note),  16'(exp_nn[c]));
      chk("song_done", c, 16'(song_done), 16'(exp_sd[c]));
      if (exp_nn[c]) begin
        chk("note",     c, 16'(note),     16'(exp_note[c]));
        chk("duration", c, 16'(duration), 16'(exp_dur[c]));
      end
      if (exp_av[c]) chk("fetch_addr", c, 16'(rom_addr), 16'(exp_addr[c]));
      next_cycle();
    end
  endtask

  initial begin
    reset = 1'b0;
    play  = 1'b0;
    beat  = 1'b0;
    song  = 2'd0;
    for (int i = 0; i < 512; i++) rom[i] = END_E;

    // Basic issue: one note, one-beat wait, end.
    fill_region(0, END_E);
    rom[0] = note_e(37, 4);
    rom[1] = wait_e(1);
    for (int c = 0; c < 1024; c++) begin
      play_a[c] = 1'b1;
      beat_a[c] = (c % 9 == 8);
    end
    run_model(0, 40);

    // Chord: three notes back to back then a four-beat wait.
    fill_region(2, END_E);
    rom[256] = note_e(37, 3);
    rom[257] = note_e(41, 3);
    rom[258] = note_e(44, 0);
    rom[259] = wait_e(4);
    rom[260] = note_e(50, 2);
    for (int c = 0; c < 1024; c++) begin
      play_a[c] = 1'b1;
      beat_a[c] = (c % 5 == 4);
    end
    run_model(2, 60);

    // Pause inside a three-beat wait; beats while paused must not count.
    fill_region(3, END_E);
    rom[384] = note_e(5, 1);
    rom[385] = wait_e(3);
    rom[386] = note_e(6, 2);
    for (int c = 0; c < 1024; c++) begin
      play_a[c] = !(c >= 12 && c <= 30);
      beat_a[c] = (c == 10) || (c >= 14 && c <= 22 && c % 2 == 0) || (c == 33) || (c == 36);
    end
    run_model(3, 60);

    // Wrap: a full region of notes with no end marker.
    for (int i = 0; i < 128; i++) rom[128 + i] = note_e(i % 64, (i * 7) % 64);
    for (int c = 0; c < 1024; c++) begin
      play_a[c] = 1'b1;
      beat_a[c] = 1'b0;
    end
    run_model(1, 420);

    // Randomized songs, play gaps and beats.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 128; i++)
        rom[r*128 + i] = ($urandom_range(0, 9) < 7) ?
                         note_e($urandom_range(0, 63), $urandom_range(0, 63)) :
                         wait_e($urandom_range(1, 3));
      rom[r*128 + $urandom_range(6, 20)] = END_E;
      for (int c = 0; c < 1024; c++) begin
        play_a[c] = ($urandom_range(0, 7) != 0);
        beat_a[c] = ($urandom_range(0, 3) == 0);
      end
      run_model(r, 300);
    end

    // Song change mid-wait restarts from entry 0 of the new song.
    fill_region(0, END_E);
    rom[0] = note_e(10, 2);
    rom[1] = wait_e(10);
    fill_region(1, END_E);
    rom[128] = note_e(20, 3);
    rom[129] = wait_e(1);
    do_reset(2'd0);
    play = 1'b1;
    repeat (8) next_cycle();
    chk("wait_addr", 8, 16'(rom_addr), 16'h002);
    song = 2'd1;
    next_cycle();
    chk("chg_addr", 9, 16'(rom_addr), 16'h080);
    chk("chg_strobe", 9, 16'(new_note), 16'h0);
    next_cycle();
    chk("chg_fetch_addr", 10, 16'(rom_addr), 16'h080);
    next_cycle();
    chk("chg_no_strobe", 11, 16'(new_note), 16'h0);
    next_cycle();
    chk("chg_new_note", 12, 16'(new_note), 16'h1);
    chk("chg_note", 12, 16'(note), 16'd20);
    chk("chg_duration", 12, 16'(duration), 16'd3);

    // Song change during DECODE of a note drops the strobe.
    do_reset(2'd0);
    play = 1'b1;
    repeat (2) next_cycle();
    song = 2'd1;
    next_cycle();
    chk("drop_strobe", 3, 16'(new_note), 16'h0);
    chk("drop_addr", 3, 16'(rom_addr), 16'h080);

    // Asynchronous reset in the NOTE_OUT cycle.
    do_reset(2'd1);
    play = 1'b1;
    repeat (4) next_cycle();
    chk("pre_rst_new_note", 4, 16'(new_note), 16'h1);
    chk("pre_rst_addr", 4, 16'(rom_addr), 16'h080);
    #2;
    reset = 1'b0;
    #1;
    chk("async_new_note", 4, 16'(new_note), 16'h0);
    chk("async_note", 4, 16'(note), 16'h0);
    chk("async_duration", 4, 16'(duration), 16'h0);
    chk("async_addr", 4, 16'(rom_addr), 16'h0);
    next_cycle();
    reset = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
